// File: rtl/l4_extract_pkg.sv
// Shared types for the L4 header field extractor: payload FSM states and the
// beat record carried through the payload skidbuffer.
package l4_extract_pkg;

    typedef enum logic {
        HDR,
        BODY
    } state_e;

    typedef struct packed {
        logic [7:0] tdata;
        logic       tlast;
        logic       tuser;
    } beat_t;

    localparam int IP_HDR_W = 160;
    localparam int BEAT_W   = $bits(beat_t);

endpackage

// File: rtl/ip_intf.sv
// IP header sideband plus 8-bit AXI-stream payload, as used between the
// network processor's IP decapsulation and socket demux stages.
interface ip_intf;
    logic         hdr_valid;
    logic         hdr_ready;
    logic [159:0] ip_hdr;
    logic [47:0]  eth_dest_mac;
    logic [47:0]  eth_src_mac;
    logic [15:0]  eth_type;
    logic [7:0]   tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic         tuser;
    logic [7:0]   tid;
    logic [7:0]   tdest;

    modport MASTER (
        output hdr_valid, ip_hdr, eth_dest_mac, eth_src_mac, eth_type,
        output tdata, tvalid, tlast, tuser, tid, tdest,
        input  hdr_ready, tready
    );

    modport SLAVE (
        input  hdr_valid, ip_hdr, eth_dest_mac, eth_src_mac, eth_type,
        input  tdata, tvalid, tlast, tuser, tid, tdest,
        output hdr_ready, tready
    );
endinterface

// File: rtl/skidbuffer.sv
// Two-entry registered skidbuffer: full throughput, one cycle of latency,
// and an input ready that depends only on local state.
module skidbuffer #(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [DW-1:0] s_data_i,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [DW-1:0] m_data_o
);
    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [DW-1:0] skid_data_q, skid_data_d;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (m_ready_i || !out_valid_q) begin
            // A parked beat always drains first; input is blocked while it exists.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = s_valid_i;
                if (s_valid_i) out_data_d = s_data_i;
            end
        end else if (s_valid_i && !skid_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign s_ready_o = !skid_valid_q;
    assign m_valid_o = out_valid_q;
    assign m_data_o  = out_data_q;

endmodule

// File: rtl/l4_hdr_field_extract.sv
// Consumes the L4 header at the start of each IP payload, captures one
// big-endian field from it, and strips or forwards the header bytes.
module l4_hdr_field_extract
    import l4_extract_pkg::*;
#(
    parameter int HDR_BYTES    = 20,
    parameter int FIELD_OFFSET = 2,
    parameter int FIELD_BYTES  = 2,
    parameter int STRIP        = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    ip_intf.SLAVE                    s_ip,
    ip_intf.MASTER                   m_ip,
    output logic [8*FIELD_BYTES-1:0] o_field,
    output logic                     o_field_valid,
    output logic                     o_short_pkt
);
    localparam int CW = $clog2(HDR_BYTES + 1);
    localparam int FW = 8 * FIELD_BYTES;
    localparam logic [CW-1:0] LAST_C = CW'(HDR_BYTES - 1);
    localparam logic [CW-1:0] FO_C   = CW'(FIELD_OFFSET);
    localparam logic [CW-1:0] FB_C   = CW'(FIELD_BYTES);

    generate
        if (FIELD_OFFSET + FIELD_BYTES > HDR_BYTES || HDR_BYTES < 1 || FIELD_BYTES < 1) begin : g_bad_cfg
            $error("l4_hdr_field_extract: captured field must lie inside the header");
        end
    endgenerate

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] field_q, field_d;
    logic          fv_q, fv_d;
    logic          fv_clr_q, fv_clr_d;
    logic          short_q, short_d;

    logic          in_hdr, last_hdr, accept, in_field;
    logic [CW-1:0] rel;
    logic          pl_valid, pl_ready;
    beat_t         in_beat, out_beat;
    logic [BEAT_W-1:0] pl_out;
    logic          unused_sideband;

    assign in_hdr   = (state_q == HDR);
    assign last_hdr = (cnt_q == LAST_C);
    assign accept   = s_ip.tvalid && s_ip.tready;
    // Wrapping subtraction turns the two-sided range test into one compare.
    assign rel      = cnt_q - FO_C;
    assign in_field = (rel < FB_C);

    assign s_ip.tready = (in_hdr && STRIP != 0) ? 1'b1 : pl_ready;
    assign pl_valid    = s_ip.tvalid && (!in_hdr || STRIP == 0);

    assign in_beat.tdata = s_ip.tdata;
    assign in_beat.tlast = s_ip.tlast;
    assign in_beat.tuser = s_ip.tuser || (in_hdr && s_ip.tlast && !last_hdr);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        field_d  = field_q;
        fv_d     = fv_q;
        fv_clr_d = fv_clr_q;
        short_d  = 1'b0;
        if (fv_clr_q) begin
            fv_d     = 1'b0;
            fv_clr_d = 1'b0;
        end
        if (accept) begin
            if (in_hdr) begin
                if (in_field) field_d = (field_q << 8) | FW'(s_ip.tdata);
                if (s_ip.tlast) begin
                    cnt_d   = '0;
                    short_d = !last_hdr;
                    // Empty payload: field is valid for exactly one cycle.
                    if (last_hdr) begin
                        fv_d     = 1'b1;
                        fv_clr_d = 1'b1;
                    end
                end else if (last_hdr) begin
                    cnt_d   = '0;
                    state_d = BODY;
                    fv_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (s_ip.tlast) begin
                state_d = HDR;
                fv_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= HDR;
            cnt_q    <= '0;
            field_q  <= '0;
            fv_q     <= 1'b0;
            fv_clr_q <= 1'b0;
            short_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            field_q  <= field_d;
            fv_q     <= fv_d;
            fv_clr_q <= fv_clr_d;
            short_q  <= short_d;
        end
    end

    assign o_field       = field_q;
    assign o_field_valid = fv_q;
    assign o_short_pkt   = short_q;

    skidbuffer #(.DW(IP_HDR_W)) u_hdr_skid (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .s_valid_i (s_ip.hdr_valid),
        .s_ready_o (s_ip.hdr_ready),
        .s_data_i  (s_ip.ip_hdr),
        .m_valid_o (m_ip.hdr_valid),
        .m_ready_i (m_ip.hdr_ready),
        .m_data_o  (m_ip.ip_hdr)
    );

    skidbuffer #(.DW(BEAT_W)) u_pl_skid (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .s_valid_i (pl_valid),
        .s_ready_o (pl_ready),
        .s_data_i  (in_beat),
        .m_valid_o (m_ip.tvalid),
        .m_ready_i (m_ip.tready),
        .m_data_o  (pl_out)
    );

    assign out_beat          = beat_t'(pl_out);
    assign m_ip.tdata        = out_beat.tdata;
    assign m_ip.tlast        = out_beat.tlast;
    assign m_ip.tuser        = out_beat.tuser;
    assign m_ip.tid          = '0;
    assign m_ip.tdest        = '0;
    assign m_ip.eth_src_mac  = '0;
    assign m_ip.eth_dest_mac = '0;
    assign m_ip.eth_type     = '0;

    assign unused_sideband = ^{s_ip.eth_dest_mac, s_ip.eth_src_mac, s_ip.eth_type, s_ip.tid, s_ip.tdest};

endmodule

// File: tb/tb_l4_hdr_field_extract.sv
// Bench for l4_hdr_field_extract: default strip config (A) and a forwarding
// UDP-source config (B), directed vectors plus reset and random-ready runs.
module tb_l4_hdr_field_extract;

    typedef logic [7:0] bytes_t[$];
    typedef logic [9:0] beats_t[$];

    typedef struct {
        int          sel;
        int          len;
        logic [31:0] h4;
        logic [15:0] exp_field;
        int          exp_fvc;
        int          exp_short;
        int          exp_beats;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    initial forever #5 clk = ~clk;

    ip_intf sa();
    ip_intf ma();
    ip_intf sb();
    ip_intf mb();

    logic [1:0]   in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         out_rdy;
    logic         hdr_v;
    logic [159:0] hdr_d;
    logic         rnd;

    logic [15:0] fld_a, fld_b;
    logic        fv_a, fv_b, sp_a, sp_b;

    assign sa.tvalid = in_valid[0];
    assign sa.tdata = in_data;
    assign sa.tlast = in_last;
    assign sa.tuser = 1'b0;
    assign sa.hdr_valid = hdr_v;
    assign sa.ip_hdr = hdr_d;
    assign sa.eth_dest_mac = '0;
    assign sa.eth_src_mac = '0;
    assign sa.eth_type = '0;
    assign sa.tid = '0;
    assign sa.tdest = '0;
    assign sb.tvalid = in_valid[1];
    assign sb.tdata = in_data;
    assign sb.tlast = in_last;
    assign sb.tuser = 1'b0;
    assign sb.hdr_valid = 1'b0;
    assign sb.ip_hdr = '0;
    assign sb.eth_dest_mac = '0;
    assign sb.eth_src_mac = '0;
    assign sb.eth_type = '0;
    assign sb.tid = '0;
    assign sb.tdest = '0;
    assign ma.tready = out_rdy;
    assign ma.hdr_ready = 1'b1;
    assign mb.tready = out_rdy;
    assign mb.hdr_ready = 1'b1;

    l4_hdr_field_extract u_a (
        .i_clk(clk), .i_rst_n(rst_n), .s_ip(sa), .m_ip(ma),
        .o_field(fld_a), .o_field_valid(fv_a), .o_short_pkt(sp_a)
    );

    l4_hdr_field_extract #(.HDR_BYTES(8), .FIELD_OFFSET(0), .FIELD_BYTES(2), .STRIP(0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .s_ip(sb), .m_ip(mb),
        .o_field(fld_b), .o_field_valid(fv_b), .o_short_pkt(sp_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitors: record output beats, field captures, short pulses, valid cycles.
    beats_t got_a, got_b;
    logic [15:0] fq_a[$];
    logic [15:0] fq_b[$];
    int short_a, short_b, fvc_a, fvc_b;
    int cyc = 0, t_first_b = -1, t_last_b = -1;
    logic pv_a = 0, pr_a = 0, fvp_a = 0, pv_b = 0, pr_b = 0, fvp_b = 0;
    logic [9:0] pd_a, pd_b;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pv_a = 0; fvp_a = 0;
            continue;
        end
        if (pv_a && !pr_a) chk("hold_a", {ma.tvalid, ma.tlast, ma.tuser, ma.tdata}, {1'b1, pd_a});
        if (ma.tvalid && ma.tready) got_a.push_back({ma.tlast, ma.tuser, ma.tdata});
        pv_a = ma.tvalid; pr_a = ma.tready; pd_a = {ma.tlast, ma.tuser, ma.tdata};
        if (sp_a) short_a++;
        if (fv_a) fvc_a++;
        if (fv_a && !fvp_a) fq_a.push_back(fld_a);
        fvp_a = fv_a;
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pv_b = 0; fvp_b = 0;
            continue;
        end
        if (pv_b && !pr_b) chk("hold_b", {mb.tvalid, mb.tlast, mb.tuser, mb.tdata}, {1'b1, pd_b});
        if (mb.tvalid && mb.tready) begin
            got_b.push_back({mb.tlast, mb.tuser, mb.tdata});
            if (t_first_b < 0) t_first_b = cyc;
            t_last_b = cyc;
        end
        pv_b = mb.tvalid; pr_b = mb.tready; pd_b = {mb.tlast, mb.tuser, mb.tdata};
        if (sp_b) short_b++;
        if (fv_b) fvc_b++;
        if (fv_b && !fvp_b) fq_b.push_back(fld_b);
        fvp_b = fv_b;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic bytes_t mk_pkt(input int len, input int hdr, input logic [31:0] h4);
        bytes_t q;
        for (int i = 0; i < len; i++)
            q.push_back(i < 4 ? h4[31-8*i -: 8] : (i >= hdr ? 8'(8'hA0 + i - hdr) : 8'(i)));
        return q;
    endfunction

    // Expected output stream: header dropped when stripping, short tlast tagged when forwarding.
    function automatic beats_t model(input bytes_t q, input int hdr, input bit strip);
        beats_t r;
        for (int i = 0; i < q.size(); i++) begin
            logic lst, usr;
            if (strip && i < hdr) continue;
            lst = (i == q.size() - 1);
            usr = lst && (q.size() < hdr) && !strip;
            r.push_back({lst, usr, q[i]});
        end
        return r;
    endfunction

    task automatic send(input int sel, input bytes_t b, input bit with_last);
        for (int i = 0; i < b.size(); i++) begin
            int t;
            logic rdy;
            in_valid = (sel == 0) ? 2'b01 : 2'b10;
            in_data  = b[i];
            in_last  = with_last && (i == b.size() - 1);
            t = 0;
            @(negedge clk);
            rdy = (sel == 0) ? sa.tready : sb.tready;
            while (!rdy && t < 1000) begin
                @(negedge clk);
                rdy = (sel == 0) ? sa.tready : sb.tready;
                t++;
            end
            if (t >= 1000) chk("in_accept", {159'd0, rdy}, 160'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 2'b00;
        in_last  = 1'b0;
    endtask

    task automatic clear_mon();
        got_a.delete(); got_b.delete(); fq_a.delete(); fq_b.delete();
        short_a = 0; short_b = 0; fvc_a = 0; fvc_b = 0;
        t_first_b = -1; t_last_b = -1;
    endtask

    vec_t vecs[8];

    initial begin
        bytes_t pkt, part;
        beats_t got, exp;
        logic [15:0] efld[$];
        logic [15:0] fq[$];
        int sh, fvc, t;
        string nm;

        vecs[0] = '{0, 24, 32'h12340050, 16'h0050, 4, 0, 4};
        vecs[1] = '{0,  5, 32'h12345678, 16'h0000, 0, 1, 0};
        vecs[2] = '{0, 24, 32'hDEADBEEF, 16'hBEEF, 4, 0, 4};
        vecs[3] = '{0, 20, 32'h01020304, 16'h0304, 1, 0, 0};
        vecs[4] = '{1, 11, 32'hC0010008, 16'hC001, 3, 0, 11};
        vecs[5] = '{1,  3, 32'h11223344, 16'h0000, 0, 1, 3};
        vecs[6] = '{1,  8, 32'hAABBCCDD, 16'hAABB, 1, 0, 8};
        vecs[7] = '{0, 21, 32'hFF008001, 16'h8001, 1, 0, 1};

        in_valid = 2'b00; in_data = '0; in_last = 0; hdr_v = 0; hdr_d = '0;
        rnd = 0; out_rdy = 1; rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid_a", ma.tvalid, 0);
        chk("rst_hdrvalid_a", ma.hdr_valid, 0);
        chk("rst_field_a", fld_a, 0);
        chk("rst_fv_a", fv_a, 0);
        chk("rst_short_a", sp_a, 0);
        chk("rst_tvalid_b", mb.tvalid, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;

        // IP header sideband through its own skidbuffer.
        hdr_d = {5{32'h4500_1C2D}} ^ 160'h1;
        hdr_v = 1;
        t = 0;
        @(negedge clk);
        while (!sa.hdr_ready && t < 20) begin @(negedge clk); t++; end
        @(posedge clk);
        #1;
        hdr_v = 0;
        t = 0;
        while (!ma.hdr_valid && t < 20) begin @(negedge clk); t++; end
        chk("hdr_valid", ma.hdr_valid, 1);
        chk("hdr_data", ma.ip_hdr, {5{32'h4500_1C2D}} ^ 160'h1);
        chk("eth_zero", {ma.eth_src_mac, ma.eth_dest_mac, ma.eth_type, ma.tid, ma.tdest}, 0);
        repeat (3) @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            int hdr;
            hdr = (vecs[v].sel == 0) ? 20 : 8;
            clear_mon();
            pkt = mk_pkt(vecs[v].len, hdr, vecs[v].h4);
            send(vecs[v].sel, pkt, 1);
            repeat (8) @(posedge clk);
            #1;
            if (vecs[v].sel == 0) begin
                got = got_a; fq = fq_a; sh = short_a; fvc = fvc_a;
            end else begin
                got = got_b; fq = fq_b; sh = short_b; fvc = fvc_b;
            end
            exp = model(pkt, hdr, vecs[v].sel == 0);
            nm = $sformatf("v%0d", v);
            chk({nm, "_beats"}, got.size(), vecs[v].exp_beats);
            for (int i = 0; i < got.size() && i < exp.size(); i++)
                chk($sformatf("%s_beat%0d", nm, i), got[i], exp[i]);
            chk({nm, "_short"}, sh, vecs[v].exp_short);
            chk({nm, "_fv_cycles"}, fvc, vecs[v].exp_fvc);
            chk({nm, "_fv_rises"}, fq.size(), (vecs[v].exp_fvc > 0) ? 1 : 0);
            if (fq.size() > 0 && vecs[v].exp_fvc > 0) chk({nm, "_field"}, fq[0], vecs[v].exp_field);
        end

        // Back-to-back forwarding packets: no idle output cycle, counter restarts.
        clear_mon();
        send(1, mk_pkt(11, 8, 32'hC0010008), 1);
        send(1, mk_pkt(10, 8, 32'h12340000), 1);
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_beats", got_b.size(), 21);
        chk("b2b_span", t_last_b - t_first_b + 1, 21);
        chk("b2b_fields", fq_b.size(), 2);
        if (fq_b.size() == 2) begin
            chk("b2b_field0", fq_b[0], 16'hC001);
            chk("b2b_field1", fq_b[1], 16'h1234);
        end

        // Asynchronous reset in the middle of a body.
        clear_mon();
        pkt = mk_pkt(40, 20, 32'h0A0B0C0D);
        part = pkt[0:23];
        send(0, part, 0);
        chk("pre_rst_tvalid", ma.tvalid, 1);
        chk("pre_rst_fv", fv_a, 1);
        #1;
        rst_n = 0;
        #1;
        chk("mid_rst_tvalid", ma.tvalid, 0);
        chk("mid_rst_hdrvalid", ma.hdr_valid, 0);
        chk("mid_rst_field", fld_a, 0);
        chk("mid_rst_fv", fv_a, 0);
        chk("mid_rst_short", sp_a, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;

        // 100 random packets against a random output ready.
        clear_mon();
        exp.delete();
        efld.delete();
        rnd = 1;
        for (int p = 0; p < 100; p++) begin
            beats_t e;
            int len;
            len = $urandom_range(21, 60);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
            efld.push_back({pkt[2], pkt[3]});
            e = model(pkt, 20, 1);
            foreach (e[i]) exp.push_back(e[i]);
            send(0, pkt, 1);
        end
        t = 0;
        while (got_a.size() < exp.size() && t < 3000) begin @(posedge clk); t++; end
        rnd = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("rand_beats", got_a.size(), exp.size());
        for (int i = 0; i < got_a.size() && i < exp.size(); i++)
            if (got_a[i] !== exp[i]) chk($sformatf("rand_beat%0d", i), got_a[i], exp[i]);
            else checks++;
        chk("rand_fields", fq_a.size(), 100);
        for (int i = 0; i < fq_a.size() && i < 100; i++)
            chk($sformatf("rand_field%0d", i), fq_a[i], efld[i]);
        chk("rand_short", short_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
